// File: rtl/rc4_keystream_decrypt.sv
// rc4_keystream_decrypt
//   RC4 PRGA stage of the decryption datapath. Walks the already-shuffled
//   S array, XORs each keystream byte with one encrypted ROM byte and
//   writes the plaintext to the decrypted RAM. Optionally aborts on the
//   first plaintext byte outside {space, 'a'..'z'}, so a bad key can be
//   rejected early.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   start               begin a run (only sampled in IDLE)
//   s_address/s_data/s_wren/s_q       S RAM port (read data one cycle late)
//   rom_address/rom_q                 encrypted ROM port (one cycle late)
//   dec_address/dec_data/dec_wren     decrypted RAM write port
//   done                one-cycle pulse at the end of a run
//   key_ok              1 = all bytes passed the check; valid from done,
//                       held until the next start
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for start
// INC_I   | i <= i+1
// RD_SI_A | drive s_address = i
// RD_SI   | capture si = s[i]
// UPD_J   | j <= j+si
// RD_SJ_A | drive s_address = j
// RD_SJ   | capture sj = s[j]
// WR_SI   | s[i] <= sj
// WR_SJ   | s[j] <= si
// RD_F_A  | drive s_address = si+sj, rom_address = k
// RD_F    | capture keystream byte f and encrypted byte ek
// WR_DEC  | dec[k] <= f^ek, check, advance or finish
// DONE    | pulse done, return to IDLE
module rc4_keystream_decrypt #(
  parameter int MSG_LENGTH  = 32,
  parameter int MSG_ADDR_W  = 5,
  parameter int CHECK_CHARS = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [7:0]            s_address,
  output logic [7:0]            s_data,
  output logic                  s_wren,
  input  logic [7:0]            s_q,
  output logic [MSG_ADDR_W-1:0] rom_address,
  input  logic [7:0]            rom_q,
  output logic [MSG_ADDR_W-1:0] dec_address,
  output logic [7:0]            dec_data,
  output logic                  dec_wren,
  output logic                  done,
  output logic                  key_ok
);

  localparam logic [MSG_ADDR_W-1:0] K_LAST = MSG_ADDR_W'(MSG_LENGTH - 1);

  typedef enum logic [3:0] {
    IDLE, INC_I, RD_SI_A, RD_SI, UPD_J, RD_SJ_A, RD_SJ,
    WR_SI, WR_SJ, RD_F_A, RD_F, WR_DEC, DONE
  } state_t;

  state_t state, state_nx;

  logic [7:0]            i, j, si, sj, f, ek;
  logic [MSG_ADDR_W-1:0] k;
  logic                  fail;
  logic [7:0]            plain;
  logic                  byte_bad;
  logic                  last_byte;

  assign plain     = f ^ ek;
  assign byte_bad  = (CHECK_CHARS != 0) &&
                     !((plain == 8'h20) || ((plain >= 8'h61) && (plain <= 8'h7A)));
  assign last_byte = (k == K_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Inactive outputs sit at 0 so they are never X and stay flat between
  // active states.
  always_comb begin
    state_nx    = state;
    s_address   = '0;
    s_data      = '0;
    s_wren      = 1'b0;
    rom_address = '0;
    dec_address = '0;
    dec_data    = '0;
    dec_wren    = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE:    if (start) state_nx = INC_I;
      INC_I:   state_nx = RD_SI_A;
      RD_SI_A: begin s_address = i; state_nx = RD_SI; end
      RD_SI:   begin s_address = i; state_nx = UPD_J; end
      UPD_J:   state_nx = RD_SJ_A;
      RD_SJ_A: begin s_address = j; state_nx = RD_SJ; end
      RD_SJ:   begin s_address = j; state_nx = WR_SI; end
      WR_SI: begin
        s_address = i;
        s_data    = sj;
        s_wren    = 1'b1;
        state_nx  = WR_SJ;
      end
      WR_SJ: begin
        s_address = j;
        s_data    = si;
        s_wren    = 1'b1;
        state_nx  = RD_F_A;
      end
      // si/sj are the pre-swap values; their sum equals s[i]+s[j] after
      // the swap, and the read lands after both writes.
      RD_F_A: begin
        s_address   = si + sj;
        rom_address = k;
        state_nx    = RD_F;
      end
      RD_F: begin
        s_address   = si + sj;
        rom_address = k;
        state_nx    = WR_DEC;
      end
      WR_DEC: begin
        dec_address = k;
        dec_data    = plain;
        dec_wren    = 1'b1;
        if (byte_bad || last_byte) state_nx = DONE;
        else                       state_nx = INC_I;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      i      <= '0;
      j      <= '0;
      k      <= '0;
      si     <= '0;
      sj     <= '0;
      f      <= '0;
      ek     <= '0;
      fail   <= 1'b0;
      key_ok <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          i      <= '0;
          j      <= '0;
          k      <= '0;
          fail   <= 1'b0;
          key_ok <= 1'b0;
        end
        INC_I: i  <= i + 8'd1;
        RD_SI: si <= s_q;
        UPD_J: j  <= j + si;
        RD_SJ: sj <= s_q;
        RD_F: begin
          f  <= s_q;
          ek <= rom_q;
        end
        WR_DEC: begin
          if (byte_bad)        fail <= 1'b1;
          else if (!last_byte) k    <= k + MSG_ADDR_W'(1);
          // Load the verdict on the way into DONE so it is already valid
          // while done is high.
          if (byte_bad || last_byte) key_ok <= !(fail || byte_bad);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_keystream_decrypt.sv
// Bench for rc4_keystream_decrypt. Three instances: two with a 3-byte
// message (character check on/off) and one at the default 32 bytes.
// Each has its own S RAM / ROM / decrypted RAM model with one-cycle reads.
module tb_rc4_keystream_decrypt;
  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       start       [NI];
  logic [7:0] s_address   [NI];
  logic [7:0] s_data      [NI];
  logic       s_wren      [NI];
  logic [7:0] s_q         [NI];
  logic [4:0] rom_address [NI];
  logic [7:0] rom_q       [NI];
  logic [4:0] dec_address [NI];
  logic [7:0] dec_data    [NI];
  logic       dec_wren    [NI];
  logic       done        [NI];
  logic       key_ok      [NI];

  always #5 clk = ~clk;

  rc4_keystream_decrypt #(.MSG_LENGTH(3), .MSG_ADDR_W(5), .CHECK_CHARS(1)) dut0 (
    .clk(clk), .reset(reset), .start(start[0]),
    .s_address(s_address[0]), .s_data(s_data[0]), .s_wren(s_wren[0]), .s_q(s_q[0]),
    .rom_address(rom_address[0]), .rom_q(rom_q[0]),
    .dec_address(dec_address[0]), .dec_data(dec_data[0]), .dec_wren(dec_wren[0]),
    .done(done[0]), .key_ok(key_ok[0]));

  rc4_keystream_decrypt #(.MSG_LENGTH(3), .MSG_ADDR_W(5), .CHECK_CHARS(0)) dut1 (
    .clk(clk), .reset(reset), .start(start[1]),
    .s_address(s_address[1]), .s_data(s_data[1]), .s_wren(s_wren[1]), .s_q(s_q[1]),
    .rom_address(rom_address[1]), .rom_q(rom_q[1]),
    .dec_address(dec_address[1]), .dec_data(dec_data[1]), .dec_wren(dec_wren[1]),
    .done(done[1]), .key_ok(key_ok[1]));

  rc4_keystream_decrypt dut2 (
    .clk(clk), .reset(reset), .start(start[2]),
    .s_address(s_address[2]), .s_data(s_data[2]), .s_wren(s_wren[2]), .s_q(s_q[2]),
    .rom_address(rom_address[2]), .rom_q(rom_q[2]),
    .dec_address(dec_address[2]), .dec_data(dec_data[2]), .dec_wren(dec_wren[2]),
    .done(done[2]), .key_ok(key_ok[2]));

  // memory models and activity counters
  logic [7:0]    s_mem   [NI][256];
  logic [7:0]    rom_mem [NI][32];
  logic [7:0]    dec_mem [NI][32];
  logic [7:0]    s_init  [256];
  logic [7:0]    rom_init[32];
  logic          init_req;
  logic [NI-1:0] init_mask;
  int            s_wren_cnt   [NI];
  int            dec_wren_cnt [NI];
  int            done_cnt     [NI];

  always @(posedge clk) begin
    for (int n = 0; n < NI; n++) begin
      if (init_req && init_mask[n]) begin
        for (int x = 0; x < 256; x++) s_mem[n][x] <= s_init[x];
        for (int x = 0; x < 32; x++) begin
          rom_mem[n][x] <= rom_init[x];
          dec_mem[n][x] <= 8'hEE;
        end
        s_wren_cnt[n]   <= 0;
        dec_wren_cnt[n] <= 0;
        done_cnt[n]     <= 0;
      end else begin
        s_q[n]   <= s_mem[n][s_address[n]];
        rom_q[n] <= rom_mem[n][rom_address[n]];
        if (s_wren[n]) begin
          s_mem[n][s_address[n]] <= s_data[n];
          s_wren_cnt[n] <= s_wren_cnt[n] + 1;
        end
        if (dec_wren[n]) begin
          dec_mem[n][dec_address[n]] <= dec_data[n];
          dec_wren_cnt[n] <= dec_wren_cnt[n] + 1;
        end
        if (done[n]) done_cnt[n] <= done_cnt[n] + 1;
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic load(input logic [NI-1:0] mask);
    @(negedge clk);
    init_mask = mask;
    init_req  = 1'b1;
    @(negedge clk);
    init_req  = 1'b0;
  endtask

  // Raises start now (caller is in an IDLE cycle); that edge is edge 0.
  // Returns the cycle in which done was seen, or -1 on budget expiry.
  task automatic run(input int n, input int budget, input bit busy_pulse,
                     input int rst_at, output int done_cyc);
    int cyc;
    start[n] = 1'b1;
    @(posedge clk); #1;
    start[n] = 1'b0;
    cyc = 1;
    while (!done[n] && cyc < budget) begin
      start[n] = busy_pulse && (cyc == 5 || cyc == 20);
      if (rst_at != 0 && cyc == rst_at) reset = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    start[n] = 1'b0;
    done_cyc = done[n] ? cyc : -1;
  endtask

  task automatic chk_abc(input string tag);
    chk({tag, "_dec0"}, dec_mem[0][0], 8'h61);
    chk({tag, "_dec1"}, dec_mem[0][1], 8'h62);
    chk({tag, "_dec2"}, dec_mem[0][2], 8'h63);
    chk({tag, "_s2"},   s_mem[0][2],   8'h03);
    chk({tag, "_s3"},   s_mem[0][3],   8'h05);
    chk({tag, "_s5"},   s_mem[0][5],   8'h02);
    chk({tag, "_keyok"}, key_ok[0],    1'b1);
  endtask

  logic [7:0] key [3];
  logic [7:0] ms  [256];
  logic [7:0] pt  [32];
  logic [7:0] mi, mj, mt, ks;
  int dc;

  initial begin
    reset     = 1'b1;
    init_req  = 1'b0;
    init_mask = '0;
    for (int n = 0; n < NI; n++) start[n] = 1'b0;
    for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
    for (int x = 0; x < 32; x++) rom_init[x] = 8'h00;
    rom_init[0] = 8'h63; rom_init[1] = 8'h67; rom_init[2] = 8'h64;
    repeat (3) @(negedge clk);
    load(3'b001);
    reset = 1'b0;
    @(negedge clk);

    // reset state
    chk("rst_s_address",   s_address[0],   8'h00);
    chk("rst_s_data",      s_data[0],      8'h00);
    chk("rst_s_wren",      s_wren[0],      1'b0);
    chk("rst_rom_address", rom_address[0], 5'h00);
    chk("rst_dec_address", dec_address[0], 5'h00);
    chk("rst_dec_data",    dec_data[0],    8'h00);
    chk("rst_dec_wren",    dec_wren[0],    1'b0);
    chk("rst_done",        done[0],        1'b0);
    chk("rst_key_ok",      key_ok[0],      1'b0);

    // identity S, "abc"
    run(0, 100, 1'b0, 0, dc);
    chk("abc_done_cyc", dc, 34);
    repeat (2) @(negedge clk);
    chk_abc("abc");
    chk("abc_s_wren_cnt",   s_wren_cnt[0],   6);
    chk("abc_dec_wren_cnt", dec_wren_cnt[0], 3);
    chk("abc_done_cnt",     done_cnt[0],     1);

    // start pulsed while busy is ignored
    load(3'b001);
    run(0, 100, 1'b1, 0, dc);
    chk("busy_done_cyc", dc, 34);
    repeat (2) @(negedge clk);
    chk_abc("busy");
    chk("busy_s_wren_cnt",   s_wren_cnt[0],   6);
    chk("busy_dec_wren_cnt", dec_wren_cnt[0], 3);
    chk("busy_done_cnt",     done_cnt[0],     1);

    // early fail on byte 0; check-off instance writes everything
    rom_init[0] = 8'h00;
    load(3'b011);
    run(0, 100, 1'b0, 0, dc);
    chk("fail_done_cyc", dc, 12);
    repeat (2) @(negedge clk);
    chk("fail_key_ok",   key_ok[0],       1'b0);
    chk("fail_dec0",     dec_mem[0][0],   8'h02);
    chk("fail_dec1",     dec_mem[0][1],   8'hEE);
    chk("fail_dec_wren", dec_wren_cnt[0], 1);
    run(1, 100, 1'b0, 0, dc);
    chk("nochk_done_cyc", dc, 34);
    repeat (2) @(negedge clk);
    chk("nochk_key_ok", key_ok[1],     1'b1);
    chk("nochk_dec0",   dec_mem[1][0], 8'h02);
    chk("nochk_dec1",   dec_mem[1][1], 8'h62);
    chk("nochk_dec2",   dec_mem[1][2], 8'h63);
    // back-to-back: start on the IDLE cycle right after DONE
    run(1, 100, 1'b0, 0, dc);
    @(posedge clk); #1;
    run(1, 100, 1'b0, 0, dc);
    chk("b2b_done_cyc", dc, 34);
    repeat (2) @(negedge clk);
    chk("b2b_done_cnt", done_cnt[1], 3);

    // reset in cycle 15, then a clean rerun
    rom_init[0] = 8'h63;
    load(3'b001);
    run(0, 60, 1'b0, 15, dc);
    chk("rst_mid_no_done", dc, -1);
    chk("rst_mid_s_wren",   s_wren_cnt[0],   2);
    chk("rst_mid_dec_wren", dec_wren_cnt[0], 1);
    chk("rst_mid_done_cnt", done_cnt[0],     0);
    chk("rst_mid_dec1",     dec_mem[0][1],   8'hEE);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run(0, 100, 1'b0, 0, dc);
    chk("rerun_done_cyc", dc, 34);
    repeat (2) @(negedge clk);
    chk_abc("rerun");

    // 32 bytes against a software RC4 model, key 00 02 49
    key[0] = 8'h00; key[1] = 8'h02; key[2] = 8'h49;
    for (int x = 0; x < 256; x++) ms[x] = 8'(x);
    mj = 8'h00;
    for (int x = 0; x < 256; x++) begin
      mj = mj + ms[x] + key[x % 3];
      mt = ms[x]; ms[x] = ms[mj]; ms[mj] = mt;
    end
    for (int x = 0; x < 256; x++) s_init[x] = ms[x];
    mi = 8'h00; mj = 8'h00;
    for (int x = 0; x < 32; x++) begin
      mi = mi + 8'd1;
      mj = mj + ms[mi];
      mt = ms[mi]; ms[mi] = ms[mj]; ms[mj] = mt;
      mt = ms[mi] + ms[mj];
      ks = ms[mt];
      pt[x] = (x % 6 == 5) ? 8'h20 : 8'(8'h61 + (x % 26));
      rom_init[x] = ks ^ pt[x];
    end
    load(3'b100);
    run(2, 400, 1'b0, 0, dc);
    chk("m32_done_cyc", dc, 353);
    repeat (2) @(negedge clk);
    chk("m32_key_ok",   key_ok[2],       1'b1);
    chk("m32_s_wren",   s_wren_cnt[2],   64);
    chk("m32_dec_wren", dec_wren_cnt[2], 32);
    for (int x = 0; x < 32; x++)  chk($sformatf("m32_dec%0d", x), dec_mem[2][x], pt[x]);
    for (int x = 0; x < 256; x++) chk($sformatf("m32_s%0d", x),   s_mem[2][x],   ms[x]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
